// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Drives a,b through the four input combinations (00, 01, 10, 11), holding
//   each for HOLD_CYCLES cycles. On the last cycle of each hold window it
//   samples y_and / y_or / y_not and compares them against the truth table.
//   Mismatching vectors are counted in a saturating counter. pass is reported
//   together with done.
//
//   Optional build macro: GATE_SWEEP_FAIL_MASK_EN
//     When defined, this adds output fail_mask[3:0].
//     Bit i of fail_mask flags that vector i mismatched.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, outputs quiet, waiting for start
//   DRIVE  | sweep in progress, current vector held on a/b
//   DONE   | sweep finished, results held until next start or reset
module gate_sweep_checker #(
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y_and,
    input  logic             y_or,
    input  logic             y_not,
    output logic             a,
    output logic             b,
    output logic [1:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef GATE_SWEEP_FAIL_MASK_EN
    ,
    output logic [3:0]       fail_mask
`endif
);

    // A hold counter of at least one bit keeps HOLD_CYCLES=1 legal.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
    logic [1:0]       vec_idx_n;
    logic             a_n, b_n;
    logic             busy_n, done_n, pass_n;
    logic [ERR_W-1:0] err_count_n;
    logic [ERR_W-1:0] err_sat_inc;
    logic             sample_hit;
    logic             vec_mismatch;

`ifdef GATE_SWEEP_FAIL_MASK_EN
    logic [3:0]       fail_mask_n;
`endif

    // The sample edge is the last cycle of the current hold window.
    // The responses are compared against the currently registered a and b.
    always_comb begin
        sample_hit   = (state == DRIVE) && (hold_cnt == CNT_LAST);
        vec_mismatch = (y_and != (a & b)) ||
                       (y_or  != (a | b)) ||
                       (y_not != ~a);
        err_sat_inc  = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
    end

    // Next-state and next-output logic for the sweep controller.
    always_comb begin
        state_n     = state;
        hold_cnt_n  = hold_cnt;
        vec_idx_n   = vec_idx;
        a_n         = a;
        b_n         = b;
        busy_n      = busy;
        done_n      = done;
        pass_n      = pass;
        err_count_n = err_count;
`ifdef GATE_SWEEP_FAIL_MASK_EN
        fail_mask_n = fail_mask;
`endif

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n     = DRIVE;
                    hold_cnt_n  = '0;
                    vec_idx_n   = 2'd0;
                    a_n         = 1'b0;
                    b_n         = 1'b0;
                    busy_n      = 1'b1;
                    done_n      = 1'b0;
                    pass_n      = 1'b0;
                    err_count_n = '0;
`ifdef GATE_SWEEP_FAIL_MASK_EN
                    fail_mask_n = 4'b0000;
`endif
                end
            end

            DRIVE: begin
                hold_cnt_n = hold_cnt + CNT_W'(1);
                if (sample_hit) begin
                    if (vec_mismatch) begin
                        err_count_n = err_sat_inc;
`ifdef GATE_SWEEP_FAIL_MASK_EN
                        fail_mask_n[vec_idx] = 1'b1;
`endif
                    end
                    hold_cnt_n = '0;
                    if (vec_idx != 2'd3) begin
                        vec_idx_n = vec_idx + 2'd1;
                        a_n       = vec_idx_n[1];
                        b_n       = vec_idx_n[0];
                    end else begin
                        // The final verdict includes the vector sampled on this edge.
                        state_n   = DONE;
                        vec_idx_n = 2'd0;
                        a_n       = 1'b0;
                        b_n       = 1'b0;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                        pass_n    = (err_count_n == '0);
                    end
                end
            end

            default: begin
                state_n   = IDLE;
                vec_idx_n = 2'd0;
                a_n       = 1'b0;
                b_n       = 1'b0;
                busy_n    = 1'b0;
                done_n    = 1'b0;
                pass_n    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts a sweep with no partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            vec_idx   <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            vec_idx   <= vec_idx_n;
            a         <= a_n;
            b         <= b_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= err_count_n;
        end
    end

`ifdef GATE_SWEEP_FAIL_MASK_EN
    // Per-vector failure flags; these are unaffected by counter saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_mask <= 4'b0000;
        end else begin
            fail_mask <= fail_mask_n;
        end
    end
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker.
// The bench models each gate as good, stuck-at-0, stuck-at-1 or inverted.
// A reference model predicts the result of each sweep from the truth table.
// A monitor checks the vector timing every cycle and pops the expected result
// when done rises.
module tb_gate_sweep_checker;

    localparam int HOLD = 10;
    localparam int EW   = 2;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          y_and, y_or, y_not;
    logic          a, b;
    logic [1:0]    vec_idx;
    logic          busy, done, pass;
    logic [EW-1:0] err_count;
`ifdef GATE_SWEEP_FAIL_MASK_EN
    logic [3:0]    fail_mask;
`endif

    int total = 0;
    int bad   = 0;

    // Fault mode for each gate: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
    int m_and = 0, m_or = 0, m_not = 0;

    typedef struct {
        int         err;
        logic       pass;
        logic [3:0] mask;
    } exp_t;

    exp_t exp_q[$];

    gate_sweep_checker #(.HOLD_CYCLES(HOLD), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .y_and(y_and), .y_or(y_or), .y_not(y_not),
        .a(a), .b(b), .vec_idx(vec_idx),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count)
`ifdef GATE_SWEEP_FAIL_MASK_EN
        , .fail_mask(fail_mask)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic faulty(logic good, int mode);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~good;
            default: return good;
        endcase
    endfunction

    assign y_and = faulty(a & b, m_and);
    assign y_or  = faulty(a | b, m_or);
    assign y_not = faulty(~a, m_not);

    // Reference model: apply each fault to the truth table and count the
    // vectors whose faulty value differs from the correct value.
    function automatic exp_t predict(int ma, int mo, int mn);
        exp_t e;
        int   cnt = 0;
        logic va, vb;
        e.mask = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            va = (v >> 1) & 1;
            vb = v & 1;
            if (faulty(va & vb, ma) != (va & vb) ||
                faulty(va | vb, mo) != (va | vb) ||
                faulty(~va, mn)     != ~va) begin
                cnt++;
                e.mask[v] = 1'b1;
            end
        end
        e.err  = (cnt > EMAX) ? EMAX : cnt;
        e.pass = (cnt == 0);
        return e;
    endfunction

    task automatic chk(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: this checks the per-cycle vector and the busy length.
    // It scores each finished sweep against the queue.
    int   busy_n    = 0;
    int   ev        = 0;
    logic prev_done = 1'b0;
    exp_t got_e;

    always @(negedge clk) begin
        if (rst) begin
            busy_n    = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                ev = busy_n / HOLD;
                chk("vec_a", int'(a), (ev >> 1) & 1);
                chk("vec_b", int'(b), ev & 1);
                chk("vec_idx", int'(vec_idx), ev & 3);
                busy_n++;
            end else begin
                chk("quiet_ab", int'({a, b}), 0);
            end
            if (done && !prev_done) begin
                chk("busy_len", busy_n, 4 * HOLD);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard: done with no expected entry at %0t", $time);
                end else begin
                    got_e = exp_q.pop_front();
                    chk("err_count", int'(err_count), got_e.err);
                    chk("pass", int'(pass), int'(got_e.pass));
`ifdef GATE_SWEEP_FAIL_MASK_EN
                    chk("fail_mask", int'(fail_mask), int'(got_e.mask));
`endif
                end
                busy_n = 0;
            end
            prev_done = done;
        end
    end

    task automatic check_all_zero(string nm);
        chk({nm, "_a"}, int'(a), 0);
        chk({nm, "_b"}, int'(b), 0);
        chk({nm, "_vec"}, int'(vec_idx), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_pass"}, int'(pass), 0);
        chk({nm, "_err"}, int'(err_count), 0);
`ifdef GATE_SWEEP_FAIL_MASK_EN
        chk({nm, "_mask"}, int'(fail_mask), 0);
`endif
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_done_clr", int'(done), 0);
        chk("start_pass_clr", int'(pass), 0);
        chk("start_err_clr", int'(err_count), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 8 * HOLD) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wait_done: done=0 after %0d cycles", n);
        end
    endtask

    task automatic run_sweep(int ma, int mo, int mn);
        m_and = ma;
        m_or  = mo;
        m_not = mn;
        exp_q.push_back(predict(ma, mo, mn));
        pulse_start();
        wait_done();
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check_all_zero("idle");

        // Directed sweeps: a clean sweep, AND stuck-at-0, NOT stuck-at-1,
        // and all three gates inverted (this saturates the counter).
        run_sweep(0, 0, 0);
        run_sweep(1, 0, 0);
        run_sweep(0, 0, 2);
        run_sweep(3, 3, 3);

        // A start pulse mid-sweep is ignored.
        m_and = 0; m_or = 2; m_not = 0;
        exp_q.push_back(predict(0, 2, 0));
        pulse_start();
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // A reset around cycle 15 of a sweep aborts it at once.
        m_and = 3; m_or = 0; m_not = 0;
        exp_q.push_back(predict(3, 0, 0));
        pulse_start();
        repeat (13) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("abort");
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        run_sweep(0, 0, 0);

        // Random fault mixes; every start after the first is issued from DONE.
        for (int i = 0; i < 12; i++) begin
            run_sweep($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        #1 chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-checking stimulus/response stage wrapped around the basic AND/OR/NOT gate cells.
- Upstream role: drives shared inputs a,b through all four combinations, holding each for a programmable number of cycles.
- Downstream role: samples y_and/y_or/y_not at the end of each hold window, compares them against expected truth-table values, and counts mismatches.
- Lets gate cells be checked in hardware or simulation without a hand-written stimulus sequence.

Parameters:
- HOLD_CYCLES, 10, cycles each input vector is held; legal range >= 1.
- ERR_W, 3, width of the saturating mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep.
- y_and  input  1  AND gate output under test.
- y_or  input  1  OR gate output under test.
- y_not  input  1  NOT gate output under test (inverts a).
- a  output  1  gate input a, registered.
- b  output  1  gate input b, registered.
- vec_idx  output  2  index of the current vector; a = vec_idx[1], b = vec_idx[0].
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start or reset.
- pass  output  1  high with done when err_count == 0; low otherwise.
- err_count  output  ERR_W  number of mismatching vectors, saturating.

Behaviour:
- Reset (async, rst=1): state=IDLE; a=b=0, vec_idx=0, busy=0, done=0, pass=0, err_count=0; hold counter=0. Reset mid-sweep aborts immediately with no partial result.
- States: IDLE, DRIVE, DONE.
- IDLE/DONE + start=1 at edge:
  - go to DRIVE; vec_idx=0, a=b=0, hold counter=0, err_count=0.
  - busy=1, done=0, pass=0 (from DONE, results cleared on that same edge).
- DRIVE:
  - Hold counter increments each cycle.
  - On the edge where hold counter == HOLD_CYCLES-1, compare inputs against expectation:
    - exp_and = a&b; exp_or = a|b; exp_not = ~a.
    - A vector mismatches if any of the three differ.
    - Each mismatching vector adds 1 to err_count, saturating at 2^ERR_W-1.
  - On that same edge:
    - if vec_idx < 3: vec_idx+1, a/b update, counter=0.
    - if vec_idx == 3: go to DONE; busy=0, done=1, pass=(final err_count==0); a=b=0, vec_idx=0.
- Timing:
  - Each vector is driven exactly HOLD_CYCLES cycles.
  - busy is high exactly 4*HOLD_CYCLES cycles.
  - Vector order: 00, 01, 10, 11 (ab).
- start while busy is ignored and has no effect.
- Outside DRIVE, a=b=0.
- y_* inputs are ignored outside the sample edge.
- HOLD_CYCLES=1: sample every cycle, vector changes every cycle.
- The sample uses the combinational response to the currently registered a,b. The gates under test must be combinational; no extra pipeline stage.

Optional Feature:
- Macro GATE_SWEEP_FAIL_MASK_EN.
- Defined: adds output fail_mask [3:0].
  - Bit i is set on the sample edge of vector i if that vector mismatched.
  - Cleared on start and reset; held through DONE.
  - Not affected by err_count saturation.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Correct gates, HOLD_CYCLES=10, start pulse:
  - a,b = 00/01/10/11, 10 cycles each; busy high 40 cycles.
  - Then done=1, pass=1, err_count=0, fail_mask=0000.
- y_and stuck at 0:
  - err_count=1, pass=0, fail_mask=1000.
- y_not stuck at 1:
  - mismatches on vectors 10 and 11; err_count=2, pass=0, fail_mask=1100.
- ERR_W=1, all three outputs inverted:
  - err_count saturates at 1, fail_mask=1111, pass=0.
- rst asserted at cycle 15 of a sweep:
  - all outputs 0 immediately (asynchronously).
  - Next start gives a full clean sweep with pass=1.
- start pulsed at cycle 5 of a sweep:
  - ignored; sweep still ends at cycle 40.
- start in DONE:
  - done/pass/err_count clear on that edge and a new sweep begins.
